// File: rtl/wb_pkg.sv
// Shared types and widths for the register-bank write-back path.
// Latency: n/a (types only). Backpressure: n/a.
package wb_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst_reg;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GR_IDLE,
        GR_READ,
        GR_WRITE
    } grant_t;
endpackage

// File: rtl/writeback_scheduler_if.sv
// Result producer, decode read request and bank write controls of the write-back scheduler.
// Latency: n/a (wires). Backpressure: res_valid/res_ready, rd_stall. Optional WB_BYPASS_EN adds forwarding.
interface writeback_scheduler_if
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  res_valid;
    logic                  res_ready;
    logic [REG_ADDR_W-1:0] res_reg;
    logic [DATA_W-1:0]     res_data;
    logic                  rd_req;
    logic [REG_ADDR_W-1:0] rd_regA;
    logic [REG_ADDR_W-1:0] rd_regB;
    logic                  rd_uses_b;
    logic                  rd_stall;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     wr_data;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [CW-1:0]         fifo_count;
`ifdef WB_BYPASS_EN
    logic                  fwd_a_valid;
    logic                  fwd_b_valid;
    logic [DATA_W-1:0]     fwd_a_data;
    logic [DATA_W-1:0]     fwd_b_data;
`endif

    modport master (
        output res_valid, res_reg, res_data, rd_req, rd_regA, rd_regB, rd_uses_b,
        input  res_ready, rd_stall, wr_en, wr_reg, wr_data, pending_mask, fifo_count
`ifdef WB_BYPASS_EN
        , input fwd_a_valid, fwd_b_valid, fwd_a_data, fwd_b_data
`endif
    );

    modport slave (
        input  res_valid, res_reg, res_data, rd_req, rd_regA, rd_regB, rd_uses_b,
        output res_ready, rd_stall, wr_en, wr_reg, wr_data, pending_mask, fifo_count
`ifdef WB_BYPASS_EN
        , output fwd_a_valid, fwd_b_valid, fwd_a_data, fwd_b_data
`endif
    );
endinterface

// File: rtl/wb_fifo.sv
// Result FIFO: storage, pointers, occupancy and per-register pending mask.
// Latency: entry visible at head the cycle after push. Backpressure: push_rdy = count<DEPTH, independent of pop.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_vld,
    output logic                push_rdy,
    input  wb_entry_t           push_dat,
    input  logic                pop,
    output wb_entry_t           head,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CW-1:0]       count
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t           ordered [DEPTH],
    output logic [DEPTH-1:0]    ordered_vld
`endif
);
    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count < CW'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; vld gates every consumer.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) pending_mask[mem[i].dst_reg] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Age-ordered view: index 0 is the oldest (head) entry.
    always_comb begin
        logic [PW-1:0] idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx            = rd_ptr + PW'(i);
            ordered[i]     = mem[idx];
            ordered_vld[i] = vld[idx];
        end
    end
`endif
endmodule

// File: rtl/writeback_scheduler.sv
// Buffers results and arbitrates the shared bank port between decode reads and queued writes (WB_BYPASS_EN: forward instead of stall).
// Latency: result pushed at edge N written at edge N+1 earliest. Backpressure: res_ready=count<DEPTH; rd_stall when read not granted.
module writeback_scheduler
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    writeback_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    grant_t              grant;
    logic                haz;
    logic                full;
    wb_entry_t           push_dat;
    wb_entry_t           head;
    logic [CW-1:0]       count;
    logic [NUM_REGS-1:0] pending;
`ifdef WB_BYPASS_EN
    wb_entry_t           ordered [DEPTH];
    logic [DEPTH-1:0]    ordered_vld;
`endif

    assign push_dat = {bus.res_reg, bus.res_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_vld     (bus.res_valid),
        .push_rdy     (bus.res_ready),
        .push_dat     (push_dat),
        .pop          (grant == GR_WRITE),
        .head         (head),
        .pending_mask (pending),
        .count        (count)
`ifdef WB_BYPASS_EN
        ,
        .ordered      (ordered),
        .ordered_vld  (ordered_vld)
`endif
    );

    assign bus.pending_mask = pending;
    assign bus.fifo_count   = count;
    assign full             = (count == CW'(DEPTH));

`ifdef WB_BYPASS_EN
    assign haz = 1'b0;
`else
    assign haz = bus.rd_req &&
                 (pending[bus.rd_regA] || (bus.rd_uses_b && pending[bus.rd_regB]));
`endif

    // A full FIDO must drain first, otherwise a stalled producer could starve writes forever.
    always_comb begin
        grant = GR_IDLE;
        if (full)                     grant = GR_WRITE;
        else if (bus.rd_req && !haz)  grant = GR_READ;
        else if (count != '0)         grant = GR_WRITE;
    end

    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_reg  = '0;
        bus.wr_data = '0;
        if (grant == GR_WRITE) begin
            bus.wr_en   = 1'b1;
            bus.wr_reg  = head.dst_reg;
            bus.wr_data = head.data;
        end
    end

    assign bus.rd_stall = bus.rd_req && (grant != GR_READ);

`ifdef WB_BYPASS_EN
    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        bus.fwd_a_valid = 1'b0;
        bus.fwd_b_valid = 1'b0;
        bus.fwd_a_data  = '0;
        bus.fwd_b_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_req && ordered_vld[i] && ordered[i].dst_reg == bus.rd_regA) begin
                bus.fwd_a_valid = 1'b1;
                bus.fwd_a_data  = ordered[i].data;
            end
            if (bus.rd_req && bus.rd_uses_b && ordered_vld[i] &&
                ordered[i].dst_reg == bus.rd_regB) begin
                bus.fwd_b_valid = 1'b1;
                bus.fwd_b_data  = ordered[i].data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_writeback_scheduler.sv
// Self-checking bench for writeback_scheduler against a queue-based reference model.
module tb_writeback_scheduler;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_scheduler_if #(.DEPTH(DEPTH)) bus ();
    writeback_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [REG_ADDR_W-1:0] r;
        logic [DATA_W-1:0]     d;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic                  exp_ready, exp_stall, exp_wr_en, exp_push, exp_pop;
    logic [REG_ADDR_W-1:0] exp_wr_reg;
    logic [DATA_W-1:0]     exp_wr_data;
    logic [NUM_REGS-1:0]   exp_mask;
    int                    exp_count;

    // Reference: queue of outstanding results, grant chosen from the priority rules.
    task automatic model_eval();
        bit haz, rd_ok;
        exp_mask = '0;
        foreach (q[i]) exp_mask[q[i].r] = 1'b1;
        exp_count = q.size();
        exp_ready = (q.size() < DEPTH);
`ifdef WB_BYPASS_EN
        haz = 1'b0;
`else
        haz = bus.rd_req && (exp_mask[bus.rd_regA] || (bus.rd_uses_b && exp_mask[bus.rd_regB]));
`endif
        rd_ok   = 1'b0;
        exp_pop = 1'b0;
        if (q.size() == DEPTH)          exp_pop = 1'b1;
        else if (bus.rd_req && !haz)    rd_ok   = 1'b1;
        else if (q.size() > 0)          exp_pop = 1'b1;
        exp_stall   = bus.rd_req && !rd_ok;
        exp_wr_en   = exp_pop;
        exp_wr_reg  = exp_pop ? q[0].r : '0;
        exp_wr_data = exp_pop ? q[0].d : '0;
        exp_push    = bus.res_valid && exp_ready;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic next();
        ent_t e;
        e.r = bus.res_reg;
        e.d = bus.res_data;
        @(posedge clk);
        if (exp_pop)  void'(q.pop_front());
        if (exp_push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.res_valid = 1'b0;
        bus.res_reg   = '0;
        bus.res_data  = '0;
        bus.rd_req    = 1'b0;
        bus.rd_regA   = '0;
        bus.rd_regB   = '0;
        bus.rd_uses_b = 1'b0;
    endtask

    task automatic push_in(input int r, input int d);
        bus.res_valid = 1'b1;
        bus.res_reg   = REG_ADDR_W'(r);
        bus.res_data  = DATA_W'(d);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.res_ready !== 1'b1 || bus.rd_stall !== 1'b0 ||
            bus.wr_reg !== '0 || bus.wr_data !== '0 || bus.pending_mask !== '0 ||
            bus.fifo_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: wr_en=%b ready=%b stall=%b reg=%0d data=%h mask=%h count=%0d, want 0 1 0 0 0 0 0",
                     bus.wr_en, bus.res_ready, bus.rd_stall, bus.wr_reg, bus.wr_data,
                     bus.pending_mask, bus.fifo_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if (bus.wr_en !== 1'b0 || bus.res_ready !== 1'b1 || bus.fifo_count !== '0 ||
                bus.pending_mask !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle c%0d: wr_en=%b ready=%b count=%0d mask=%h, want 0 1 0 0",
                         c, bus.wr_en, bus.res_ready, bus.fifo_count, bus.pending_mask);
            end
            next();
        end
    endtask

    task automatic test_single_write();
        push_in(3, 16'h1234);
        settle();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_offer: wr_en=%b ready=%b, want 0 1", bus.wr_en, bus.res_ready);
        end
        next();
        idle_inputs();
        settle();
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_reg !== 4'd3 || bus.wr_data !== 16'h1234 ||
            bus.fifo_count !== CW'(1) || bus.pending_mask !== 16'h0008) begin
            n_fail++;
            $display("FAIL single_write: wr_en=%b reg=%0d data=%h count=%0d mask=%h, want 1 3 1234 1 0008",
                     bus.wr_en, bus.wr_reg, bus.wr_data, bus.fifo_count, bus.pending_mask);
        end
        next();
        settle();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.fifo_count !== '0 || bus.pending_mask !== '0) begin
            n_fail++;
            $display("FAIL single_drained: wr_en=%b count=%0d mask=%h, want 0 0 0",
                     bus.wr_en, bus.fifo_count, bus.pending_mask);
        end
    endtask

    task automatic test_hazard_stall();
        push_in(5, 16'hBEEF);
        settle();
        next();
        idle_inputs();
        bus.rd_req  = 1'b1;
        bus.rd_regA = 4'd5;
        bus.rd_regB = 4'd9;
        settle();
        n_checks++;
`ifdef WB_BYPASS_EN
        if (bus.rd_stall !== 1'b0 || bus.wr_en !== 1'b0 || bus.fwd_a_valid !== 1'b1 ||
            bus.fwd_a_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL hazard_bypass: stall=%b wr_en=%b fwd_v=%b fwd_d=%h, want 0 0 1 beef",
                     bus.rd_stall, bus.wr_en, bus.fwd_a_valid, bus.fwd_a_data);
        end
        next();
        bus.rd_req = 1'b0;
        settle();
`else
        if (bus.rd_stall !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_reg !== 4'd5 ||
            bus.wr_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL hazard_stall: stall=%b wr_en=%b reg=%0d data=%h, want 1 1 5 beef",
                     bus.rd_stall, bus.wr_en, bus.wr_reg, bus.wr_data);
        end
        next();
        settle();
        n_checks++;
        if (bus.rd_stall !== 1'b0 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_release: stall=%b wr_en=%b, want 0 0", bus.rd_stall, bus.wr_en);
        end
`endif
        next();
        idle_inputs();
    endtask

    task automatic test_full_priority();
        logic [DATA_W-1:0] d [4];
        bus.rd_req    = 1'b1;
        bus.rd_regA   = 4'd1;
        bus.rd_regB   = 4'd2;
        bus.rd_uses_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d[k] = DATA_W'($urandom);
            push_in(8 + k, int'(d[k]));
            settle();
            n_checks++;
            if (bus.fifo_count !== CW'(k) || bus.wr_en !== 1'b0 || bus.rd_stall !== 1'b0 ||
                bus.res_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_read_priority k%0d: count=%0d wr_en=%b stall=%b ready=%b, want %0d 0 0 1",
                         k, bus.fifo_count, bus.wr_en, bus.rd_stall, bus.res_ready, k);
            end
            next();
        end
        bus.res_valid = 1'b0;
        settle();
        n_checks++;
        if (bus.fifo_count !== CW'(4) || bus.res_ready !== 1'b0 || bus.wr_en !== 1'b1 ||
            bus.wr_reg !== 4'd8 || bus.wr_data !== d[0] || bus.rd_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: count=%0d ready=%b wr_en=%b reg=%0d data=%h stall=%b, want 4 0 1 8 %h 1",
                     bus.fifo_count, bus.res_ready, bus.wr_en, bus.wr_reg, bus.wr_data,
                     bus.rd_stall, d[0]);
        end
        next();
        bus.rd_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_reg !== REG_ADDR_W'(8 + k) || bus.wr_data !== d[k]) begin
                n_fail++;
                $display("FAIL full_tail k%0d: wr_en=%b reg=%0d data=%h, want 1 %0d %h",
                         k, bus.wr_en, bus.wr_reg, bus.wr_data, 8 + k, d[k]);
            end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_same_reg();
        int exp_d [2] = '{1, 2};
        push_in(7, 1);
        settle();
        next();
        push_in(7, 2);
        for (int k = 0; k < 2; k++) begin
            settle();
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_reg !== 4'd7 || bus.wr_data !== DATA_W'(exp_d[k]) ||
                bus.pending_mask[7] !== 1'b1) begin
                n_fail++;
                $display("FAIL same_reg_order k%0d: wr_en=%b reg=%0d data=%h pend7=%b, want 1 7 %0d 1",
                         k, bus.wr_en, bus.wr_reg, bus.wr_data, bus.pending_mask[7], exp_d[k]);
            end
            next();
            bus.res_valid = 1'b0;
        end
        settle();
        n_checks++;
        if (bus.pending_mask[7] !== 1'b0 || bus.fifo_count !== '0) begin
            n_fail++;
            $display("FAIL same_reg_clear: pend7=%b count=%0d, want 0 0", bus.pending_mask[7], bus.fifo_count);
        end
`ifdef WB_BYPASS_EN
        bus.rd_req  = 1'b1;
        bus.rd_regA = 4'd1;
        push_in(7, 1);
        settle();
        next();
        push_in(7, 2);
        settle();
        next();
        bus.res_valid = 1'b0;
        bus.rd_regA   = 4'd7;
        settle();
        n_checks++;
        if (bus.fwd_a_valid !== 1'b1 || bus.fwd_a_data !== 16'h0002 || bus.rd_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_youngest: fwd_v=%b fwd_d=%h stall=%b, want 1 0002 0",
                     bus.fwd_a_valid, bus.fwd_a_data, bus.rd_stall);
        end
        next();
        bus.rd_req = 1'b0;
        settle();
        next();
        settle();
        next();
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.rd_req  = 1'b1;
        bus.rd_regA = 4'd0;
        for (int k = 0; k < 3; k++) begin
            push_in(12 + k, 16'hA000 + k);
            settle();
            next();
        end
        idle_inputs();
        settle();
        n_checks++;
        if (bus.fifo_count !== CW'(3)) begin
            n_fail++;
            $display("FAIL mid_fill: count=%0d, want 3", bus.fifo_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        n_checks++;
        if (bus.fifo_count !== '0 || bus.wr_en !== 1'b0 || bus.pending_mask !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d wr_en=%b mask=%h, want 0 0 0",
                     bus.fifo_count, bus.wr_en, bus.pending_mask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if (bus.wr_en !== 1'b0 || bus.fifo_count !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet c%0d: wr_en=%b count=%0d, want 0 0", c, bus.wr_en, bus.fifo_count);
            end
            next();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.res_valid = ($urandom_range(0, 9) < 6);
            bus.res_reg   = REG_ADDR_W'($urandom);
            bus.res_data  = DATA_W'($urandom);
            bus.rd_req    = ($urandom_range(0, 1) == 1);
            bus.rd_regA   = REG_ADDR_W'($urandom);
            bus.rd_regB   = REG_ADDR_W'($urandom);
            bus.rd_uses_b = ($urandom_range(0, 1) == 1);
            settle();
            n_checks++;
            if (bus.wr_en !== exp_wr_en || bus.wr_reg !== exp_wr_reg || bus.wr_data !== exp_wr_data) begin
                n_fail++;
                $display("FAIL rand_bank c%0d: wr_en=%b reg=%0d data=%h, want %b %0d %h",
                         c, bus.wr_en, bus.wr_reg, bus.wr_data, exp_wr_en, exp_wr_reg, exp_wr_data);
            end
            n_checks++;
            if (bus.rd_stall !== exp_stall || bus.res_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_flow c%0d: stall=%b ready=%b, want %b %b",
                         c, bus.rd_stall, bus.res_ready, exp_stall, exp_ready);
            end
            n_checks++;
            if (bus.pending_mask !== exp_mask || bus.fifo_count !== CW'(exp_count)) begin
                n_fail++;
                $display("FAIL rand_state c%0d: mask=%h count=%0d, want %h %0d",
                         c, bus.pending_mask, bus.fifo_count, exp_mask, exp_count);
            end
            next();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_hazard_stall();
        test_full_priority();
        test_same_reg();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_scheduler.md
Name: writeback_scheduler

Overview:
- Write-side companion of the 16x16 register bank. The bank has a single shared port: RW=1 writes, RW=0 reads.
- Buffers completed results (ALU/memory) in a small FIFO and drives the bank write controls (RW, regC, dado).
- Arbitrates each cycle between a decode-stage read and a buffered write, and stalls decode on read-after-write hazards against queued results.

Parameters:
- DATA_W, 16, result/register data width
- REG_ADDR_W, 4, register index width (16 registers)
- DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- res_valid  in  1  producer offers a result this cycle
- res_ready  out  1  FIFO can accept; transfer when res_valid&&res_ready
- res_reg  in  REG_ADDR_W  destination register of offered result
- res_data  in  DATA_W  offered result value
- rd_req  in  1  decode needs a bank read this cycle
- rd_regA  in  REG_ADDR_W  read operand A index
- rd_regB  in  REG_ADDR_W  read operand B index
- rd_uses_b  in  1  operand B is a real register (0 = immediate form)
- rd_stall  out  1  decode must hold; read not granted this cycle
- wr_en  out  1  to bank RW: 1 = write this edge, 0 = read
- wr_reg  out  REG_ADDR_W  to bank regC
- wr_data  out  DATA_W  to bank dado
- pending_mask  out  2**REG_ADDR_W  bit r set while any queued entry targets register r
- fifo_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0): pointers and count cleared, all entries invalid.
  - Reset values: res_ready=1, rd_stall=0, wr_en=0, wr_reg=0, wr_data=0, pending_mask=0, fifo_count=0.
  - Reset mid-operation discards queued results; nothing is written to the bank.
- Enqueue: on posedge with res_valid&&res_ready, {res_reg,res_data} is written at the tail.
  - res_ready = (count<DEPTH) and does not depend on same-cycle pop (no comb path input→ready).
- Hazard: haz = rd_req && (pending_mask[rd_regA] || (rd_uses_b && pending_mask[rd_regB])).
  - pending_mask is combinational from valid FIFO entries only; the offered, not-yet-enqueued result is excluded.
- Grant, combinational each cycle, priority order:
  1. count==DEPTH and count>0 → WRITE (full drains first).
  2. rd_req && !haz → READ.
  3. count>0 → WRITE.
  4. Otherwise → IDLE.
- Outputs per grant:
  - WRITE: wr_en=1, wr_reg/wr_data = head entry, head popped on the same posedge the bank samples.
  - READ/IDLE: wr_en=0, wr_reg=0, wr_data=0.
  - rd_stall = rd_req && grant!=READ.
- Latency: a result enqueued at edge N is written at edge N+1 at the earliest (empty FIFO, no rd_req).
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- Ordering: strict FIFO. Two queued writes to the same register land in arrival order; the pending bit clears only when the last entry for that register pops.
- Liveness: a hazard stall always drains, because a hazard implies count>0, which implies a write grant.

Optional Feature:
- Macro WB_BYPASS_EN adds ports fwd_a_valid/fwd_b_valid (1b) and fwd_a_data/fwd_b_data (DATA_W).
- With the macro:
  - A hazard no longer stalls.
  - fwd_x_valid=1 and fwd_x_data = youngest queued entry for that register.
  - Grant uses haz=0, so read proceeds.
  - Decode muxes the forwarded value over the bank output.
- Without the macro: ports absent, stall behaviour as above.

Decomposition:
- Package wb_pkg holds:
  - DATA_W, REG_ADDR_W, NUM_REGS=2**REG_ADDR_W
  - a wb_entry_t struct {reg, data}
  - a grant_t enum {GR_IDLE, GR_READ, GR_WRITE}
- Sub-module wb_fifo: storage, pointers, count, per-entry valid, pending_mask generation.
- Top holds grant logic, stall, and (optionally) forwarding.

Test Plan:
- Reset release, no stimulus → wr_en=0, res_ready=1, fifo_count=0, pending_mask=0 for 5 cycles.
- Push {r3,0x1234}, rd_req=0 → next cycle wr_en=1, wr_reg=3, wr_data=0x1234; after that edge pending_mask=0, count=0.
- Push {r5,0xBEEF}, then rd_req with rd_regA=5 → rd_stall=1 for 1 cycle while write drains, then rd_stall=0 and wr_en=0 (read granted).
- rd_req held with non-hazard regs (A=1, B=2) while pushing 4 results → writes deferred until count=4, then full-priority write with rd_stall=1 that cycle; res_ready=0 at count=4.
- Push {r7,0x0001} then {r7,0x0002} → bank sees two writes to r7 in order; pending_mask[7] stays 1 until the second pops. With WB_BYPASS_EN, rd_regA=7 gives fwd_a_data=0x0002.
- Assert rst_n=0 with count=3 → immediately count=0, wr_en=0, pending_mask=0; no further bank writes after release.
